// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide, plus MTHI/MTLO moves, with one-cycle write strobes to the HI/LO file.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst_,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] write_hilo_hi_data,
    output logic [31:0] write_hilo_lo_data,
    output logic        write_hilo_hi_data_valid,
    output logic        write_hilo_lo_data_valid
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [63:0] acc_q, acc_d;     // {hi, lo} product or {remainder, quotient}
    logic        negq_q, negq_d;   // negate product / quotient
    logic        negr_q, negr_d;   // negate remainder
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        sgn, dz;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sum, rem_sh, diff;
    logic [63:0] mul_nxt, div_nxt, acc_nxt, mul_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        // Divide-by-zero runs as an unsigned divide: the restoring loop then
        // yields quotient all-ones and remainder equal to the raw dividend.
        dz    = op[1] && (src_b == 32'd0);
        sgn   = !op[0] && !dz;
        a_mag = (sgn && src_a[31]) ? 32'd0 - src_a : src_a;
        b_mag = (sgn && src_b[31]) ? 32'd0 - src_b : src_b;

        sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_nxt = {sum, acc_q[31:1]};
        rem_sh  = {acc_q[63:32], acc_q[31]};
        diff    = rem_sh - {1'b0, opnd_q};
        div_nxt = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                           : {diff[31:0],   acc_q[30:0], 1'b1};
        acc_nxt = op_q[1] ? div_nxt : mul_nxt;
        mul_fix = negq_q ? 64'd0 - acc_nxt : acc_nxt;
        quo_fix = negq_q ? 32'd0 - acc_nxt[31:0] : acc_nxt[31:0];
        rem_fix = negr_q ? 32'd0 - acc_nxt[63:32] : acc_nxt[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush && (op <= OP_MTLO)) begin
                    op_d  = op;
                    cnt_d = 5'd0;
                    if (op[2]) begin
                        state_d = DONE;
                        if (op == OP_MTHI) hi_d = src_a;
                        else               lo_d = src_a;
                    end else begin
                        state_d = CALC;
                        negq_d  = sgn && (src_a[31] ^ src_b[31]);
                        negr_d  = sgn && src_a[31];
                        opnd_d  = op[1] ? b_mag : a_mag;
                        acc_d   = {32'd0, op[1] ? a_mag : b_mag};
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        if (op_q[1]) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else begin
                            {hi_d, lo_d} = mul_fix;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            opnd_q  <= 32'd0;
            acc_q   <= 64'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy                     = (state_q != IDLE);
    assign write_hilo_hi_data       = hi_q;
    assign write_hilo_lo_data       = lo_q;
    assign write_hilo_hi_data_valid = (state_q == DONE) && !flush && (op_q != OP_MTLO);
    assign write_hilo_lo_data_valid = (state_q == DONE) && !flush && (op_q != OP_MTHI);
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed corner cases plus random ops checked
// cycle-by-cycle against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst_, start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, hv, lv;
    logic [31:0] hi, lo;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit dut (
        .clk(clk), .rst_(rst_), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy),
        .write_hilo_hi_data(hi), .write_hilo_lo_data(lo),
        .write_hilo_hi_data_valid(hv), .write_hilo_lo_data_valid(lv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // {HI, LO} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MULT:    begin p = sa * sb; return p; end
            MULTU:   begin p = {32'd0, a} * {32'd0, b}; return p; end
            DIV:     begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            DIVU:    return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            MTHI:    return {a, 32'd0};
            default: return {32'd0, a};
        endcase
    endfunction

    // Issue at a negedge; checks busy/strobes every cycle and data on the strobe cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] exp;
        int          lat;
        logic        ehv, elv;
        exp = ref_model(o, a, b);
        lat = o[2] ? 1 : 33;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            ehv = (k == lat) && (o != MTLO);
            elv = (k == lat) && (o != MTHI);
            chk({tag, " busy/strobes"}, {29'd0, busy, hv, lv},
                {29'd0, (k <= lat) ? 1'b1 : 1'b0, ehv, elv});
            if (ehv) chk({tag, " HI"}, hi, exp[63:32]);
            if (elv) chk({tag, " LO"}, lo, exp[31:0]);
        end
    endtask

    // Flush at cycle at_k after E0 (33 = the DONE cycle); start optionally held throughout.
    task automatic flush_op(input logic [2:0] o, input int at_k, input logic hold,
                            input string tag);
        int strobes;
        start = 1'b1; op = o; src_a = $urandom; src_b = $urandom;
        @(posedge clk);
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (k == at_k) flush = 1'b1;
            #1;
            chk({tag, " pre-flush"}, {29'd0, busy, hv, lv}, 32'b100);
        end
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk({tag, " idle after flush"}, {31'd0, busy}, 32'd0);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            strobes += int'(hv) + int'(lv) + int'(busy);
        end
        chk({tag, " quiet after flush"}, strobes, 0);
    endtask

    initial begin
        int          seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_ = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset strobes", {30'd0, hv, lv}, 32'd0);
        chk("reset HI", hi, 32'd0);
        chk("reset LO", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;

        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
        run_op(MULT, -32'sd3, 32'd5, "mult -3x5");
        run_op(DIV, -32'sd7, 32'd2, "div -7/2");
        run_op(DIVU, 32'd7, 32'd0, "divu 7/0");
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
        run_op(DIV, -32'sd5, 32'd0, "div -5/0");
        run_op(DIV, 32'd7, -32'sd2, "div 7/-2");
        run_op(MTHI, 32'h12345678, 32'hDEADBEEF, "mthi");
        run_op(MTLO, 32'hCAFEF00D, 32'h0, "mtlo");

        // Illegal op codes are never accepted.
        start = 1'b1; op = 3'd6; @(negedge clk);
        chk("illegal op 6", {29'd0, busy, hv, lv}, 32'd0);
        op = 3'd7; @(negedge clk);
        chk("illegal op 7", {29'd0, busy, hv, lv}, 32'd0);
        // start together with flush in IDLE is not accepted.
        op = MULTU; flush = 1'b1; @(negedge clk);
        chk("start+flush idle", {29'd0, busy, hv, lv}, 32'd0);
        start = 1'b0; flush = 1'b0;

        flush_op(DIVU, 10, 1'b1, "flush calc it10");
        flush_op(MULT, 33, 1'b0, "flush done");

        // Asynchronous reset at iteration 20, well away from any clock edge.
        start = 1'b1; op = MULT; src_a = $urandom; src_b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst strobes", {30'd0, hv, lv}, 32'd0);
        chk("async rst HI", hi, 32'd0);
        chk("async rst LO", lo, 32'd0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen += int'(hv) + int'(lv) + int'(busy);
        end
        chk("quiet in reset", seen, 0);
        rst_ = 1'b1;
        run_op(MULTU, 32'd2, 32'd3, "multu 2x3 after rst");

        // Random back-to-back ops; each starts the cycle after the previous DONE.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and the iteration count is fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are illegal.
REQ-006 src_a  input  32  multiplicand/dividend, or MTHI/MTLO source.
REQ-007 src_b  input  32  multiplier/divisor; ignored for MTHI/MTLO.
REQ-008 flush  input  1  synchronous abort of any in-flight operation.
REQ-009 busy  output  1  high in CALC and DONE.
REQ-010 write_hilo_hi_data  output  32  HI result; feeds the register file HI write port.
REQ-011 write_hilo_lo_data  output  32  LO result; feeds the register file LO write port.
REQ-012 write_hilo_hi_data_valid  output  1  one-cycle HI write strobe.
REQ-013 write_hilo_lo_data_valid  output  1  one-cycle LO write strobe.

Function
REQ-014 The block SHALL implement three states: IDLE, CALC, DONE.
REQ-015 In IDLE, with start=1, flush=0 and a legal op, the block SHALL latch op, src_a and src_b at edge E0.
  - MUL/DIV ops -> CALC, iteration counter cleared to 0.
  - MTHI/MTLO -> DONE directly.
REQ-016 start SHALL be ignored in CALC and DONE, and for illegal op codes; the block SHALL stay in IDLE for an illegal op.
REQ-017 In CALC the block SHALL perform one iteration per edge.
  - MUL: shift-add.
  - DIV: restoring, one quotient bit per edge.
  - The 32nd iteration edge (E32) moves the state to DONE.
REQ-018 In DONE the block SHALL assert the valid strobes for exactly one cycle, then return to IDLE on the next edge.
  - MUL/DIV latency: strobes high in the cycle after E32.
  - MTHI/MTLO latency: strobes high in the cycle after E0.
REQ-019 MULT/MULTU SHALL produce a 64-bit product with HI = bits[63:32] and LO = bits[31:0].
  - MULT: signed operands. The block multiplies the magnitudes and negates the 64-bit result (two's complement) when the operand signs differ.
REQ-020 DIV/DIVU SHALL produce LO = quotient and HI = remainder.
  - DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Divide by zero (DIV or DIVU) SHALL give HI=src_a and LO=0xFFFFFFFF, with normal latency.
REQ-022 For MUL/DIV ops both valid strobes SHALL assert together.
  - MTHI: only write_hilo_hi_data_valid asserts, with HI data = src_a.
  - MTLO: only write_hilo_lo_data_valid asserts, with LO data = src_a.
REQ-023 When the valid strobes are low, the data outputs SHALL hold their last values; they are don't-care to the consumer.
REQ-024 flush=1 in CALC or DONE SHALL return the block to IDLE at the next edge and discard the partial result.
  - A flush in the DONE cycle SHALL force both strobes low combinationally in that cycle.
REQ-025 flush=1 together with start=1 in IDLE SHALL leave the request unaccepted and the state in IDLE.
REQ-026 busy SHALL be low in IDLE; a new start is accepted in the cycle after DONE at the earliest.

Reset
REQ-027 rst_=0 SHALL asynchronously force the following, regardless of clk:
  - state IDLE, counter 0, all internal datapath registers 0;
  - busy 0, both strobes 0, both data outputs 0x00000000.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no strobe at any time.
REQ-029 After rst_ deasserts, the first start SHALL be accepted at the first rising edge at which it is sampled.

Verification
REQ-030 MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> strobes high only in the cycle after E32 (busy high from E0 until E33); HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU 7 / 0 -> HI=0x00000007, LO=0xFFFFFFFF; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-033 MTHI src_a=0x12345678 -> in the cycle after E0 only the HI strobe is high, HI=0x12345678; busy low in the following cycle.
REQ-034 DIVU started, flush at iteration 10 -> IDLE at the next edge, no strobe ever; a start held during CALC is ignored and a start held on the flush cycle is not accepted.
REQ-035 rst_ pulsed low asynchronously at iteration 20 -> outputs immediately 0 and busy 0; no strobe; a fresh MULTU 2 x 3 after release -> HI=0, LO=6.
